// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin two-requester issue sequencer for a shared FP add/multiply unit
// Optional timeout/abort path enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_result,
   output logic        resp0_overflow,
   output logic        resp0_error,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_result,
   output logic        resp1_overflow,
   output logic        resp1_error,
   output logic        fpu_start,
   output logic        fpu_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result,
   input  logic        fpu_overflow,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic        last, owner;
   logic        gnt0, gnt1;
   logic        timeout_hit;
   logic [31:0] res_result;
   logic        res_overflow;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             res_error;

   // Counter saturates at its last value, so it can never wrap back into range.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state == ISSUE) begin
         cnt <= '0;
      end else if (state == WAIT && !fpu_done && cnt != CNT_LAST) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign timeout_hit = (state == WAIT) && !fpu_done && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_error <= 1'b0;
      end else if (state == WAIT && fpu_done) begin
         res_error <= 1'b0;
      end else if (timeout_hit) begin
         res_error <= 1'b1;
      end
   end

   assign resp0_error = res_error;
   assign resp1_error = res_error;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
   assign resp0_error = 1'b0;
   assign resp1_error = 1'b0;
`endif

   // On a tie the requester that did not win last time gets the grant.
   assign gnt0 = req0_valid && (!req1_valid || last);
   assign gnt1 = req1_valid && (!req0_valid || !last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      fpu_start  = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = gnt0;
            req1_ready = gnt1;
            if (gnt0 || gnt1) state_nxt = ISSUE;
         end
         ISSUE: begin
            fpu_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (fpu_done || timeout_hit) state_nxt = RESP;
         end
         RESP: begin
            if (owner ? resp1_ready : resp0_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last         <= 1'b1;
         owner        <= 1'b0;
         fpu_op       <= 1'b0;
         fpu_a        <= '0;
         fpu_b        <= '0;
         res_result   <= '0;
         res_overflow <= 1'b0;
      end else begin
         if (state == IDLE && (gnt0 || gnt1)) begin
            owner  <= gnt1;
            last   <= gnt1;
            fpu_op <= gnt1 ? req1_op : req0_op;
            fpu_a  <= gnt1 ? req1_a : req0_a;
            fpu_b  <= gnt1 ? req1_b : req0_b;
         end
         // A completion arriving on the timeout cycle still wins.
         if (state == WAIT && fpu_done) begin
            res_result   <= fpu_result;
            res_overflow <= fpu_overflow;
         end else if (timeout_hit) begin
            res_result   <= 32'h7FC0_0000;
            res_overflow <= 1'b0;
         end
      end
   end

   assign busy           = (state != IDLE);
   assign resp0_valid    = (state == RESP) && !owner;
   assign resp1_valid    = (state == RESP) && owner;
   assign resp0_result   = res_result;
   assign resp1_result   = res_result;
   assign resp0_overflow = res_overflow;
   assign resp1_overflow = res_overflow;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed self-checking bench for fpu_arbiter with an 8-cycle FP unit model
module tb_fpu_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid, req0_ready, req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp0_overflow, resp0_error;
   logic [31:0] resp0_result;
   logic        resp1_valid, resp1_ready, resp1_overflow, resp1_error;
   logic [31:0] resp1_result;
   logic        fpu_start, fpu_op, fpu_done, fpu_overflow, busy;
   logic [31:0] fpu_a, fpu_b, fpu_result;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int lat_cnt;
   logic mute = 1'b0;
   logic force_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
      .resp0_overflow(resp0_overflow), .resp0_error(resp0_error),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
      .resp1_overflow(resp1_overflow), .resp1_error(resp1_error),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_overflow(fpu_overflow),
      .busy(busy)
   );

   // FP unit stand-in: known operand pairs only, done 8 cycles after fpu_start.
   function automatic logic [32:0] fp_model(input logic op, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] key;
      key = {op, a, b};
      case (key)
         {1'b1, 32'h4120_0000, 32'h40A0_0000}: return {1'b0, 32'h4170_0000};
         {1'b0, 32'h4000_0000, 32'h4040_0000}: return {1'b0, 32'h40C0_0000};
         {1'b1, 32'h3F80_0000, 32'h3F80_0000}: return {1'b0, 32'h4000_0000};
         {1'b0, 32'h7F00_0000, 32'h7F00_0000}: return {1'b1, 32'h7F80_0000};
         default:                              return {1'b0, 32'hFFFF_FFFF};
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) lat_cnt <= 0;
      else if (fpu_start) lat_cnt <= 8;
      else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
   end

   assign fpu_done = (!mute && lat_cnt == 1) || force_done;
   assign {fpu_overflow, fpu_result} = fp_model(fpu_op, fpu_a, fpu_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input int n, output int t);
      int k = 0;
      #1;
      while (!(n == 1 ? req1_ready : req0_ready) && k < 40) begin
         @(negedge clk); #1; k++;
      end
      check($sformatf("req%0d_ready_seen", n), 32'(n == 1 ? req1_ready : req0_ready), 32'd1);
      t = cyc;
   endtask

   task automatic wait_resp(input int n, output int t);
      int k = 0;
      #1;
      while (!(n == 1 ? resp1_valid : resp0_valid) && k < 40) begin
         @(negedge clk); #1; k++;
      end
      check($sformatf("resp%0d_valid_seen", n), 32'(n == 1 ? resp1_valid : resp0_valid), 32'd1);
      t = cyc;
   endtask

   task automatic consume(input int n);
      if (n == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t0, t1, k, winner, exp_w;
      logic [31:0] exp_res [4];
      logic        exp_ov  [4];
      exp_res = '{32'h40C0_0000, 32'h4000_0000, 32'h7F80_0000, 32'h4000_0000};
      exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b0};

      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      resp0_ready = 0; resp1_ready = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_start", 32'(fpu_start), 0);
      check("rst_op", 32'(fpu_op), 0);
      check("rst_a", fpu_a, 0);
      check("rst_b", fpu_b, 0);
      check("rst_v0", 32'(resp0_valid), 0);
      check("rst_v1", 32'(resp1_valid), 0);
      check("rst_res0", resp0_result, 0);
      check("rst_err0", 32'(resp0_error), 0);
      check("rst_rdy0", 32'(req0_ready), 0);

      // single soma from req0
      req0_valid = 1; req0_op = 1; req0_a = 32'h4120_0000; req0_b = 32'h40A0_0000;
      wait_ready(0, t0);
      check("t1_rdy1", 32'(req1_ready), 0);
      @(negedge clk); req0_valid = 0; #1;
      check("t1_start", 32'(fpu_start), 1);
      check("t1_busy", 32'(busy), 1);
      check("t1_fop", 32'(fpu_op), 1);
      check("t1_fa", fpu_a, 32'h4120_0000);
      check("t1_fb", fpu_b, 32'h40A0_0000);
      @(negedge clk); #1;
      check("t1_start_pulse", 32'(fpu_start), 0);
      wait_resp(0, t1);
      check("t1_lat", 32'(t1 - t0), 10);
      check("t1_res", resp0_result, 32'h4170_0000);
      check("t1_ov", 32'(resp0_overflow), 0);
      check("t1_err", 32'(resp0_error), 0);
      check("t1_v1", 32'(resp1_valid), 0);
      consume(0);
      check("t1_v0_drop", 32'(resp0_valid), 0);
      check("t1_idle", 32'(busy), 0);

      // simultaneous requests from reset: req0 first
      reset = 1; @(negedge clk); reset = 0;
      req0_valid = 1; req0_op = 0; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
      req1_valid = 1; req1_op = 1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
      wait_ready(0, t0);
      check("t2_rdy1", 32'(req1_ready), 0);
      @(negedge clk); req0_valid = 0;
      wait_resp(0, t1);
      check("t2_res0", resp0_result, 32'h40C0_0000);
      check("t2_rdy1_resp", 32'(req1_ready), 0);
      consume(0);
      check("t2_rdy1_next", 32'(req1_ready), 1);
      t0 = cyc;
      @(negedge clk); req1_valid = 0;
      wait_resp(1, t1);
      check("t2_lat1", 32'(t1 - t0), 10);
      check("t2_res1", resp1_result, 32'h4000_0000);
      check("t2_v0", 32'(resp0_valid), 0);
      consume(1);

      // back-to-back contention: grants alternate
      req0_valid = 1; req0_op = 0; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
      req1_valid = 1;
      for (int i = 0; i < 4; i++) begin
         exp_w = i % 2;
         k = 0;
         #1;
         while (!(req0_ready || req1_ready) && k < 40) begin
            @(negedge clk); #1; k++;
         end
         winner = req1_ready ? 1 : 0;
         check($sformatf("t3_grant%0d", i), 32'(winner), 32'(exp_w));
         check($sformatf("t3_any%0d", i), 32'(req0_ready || req1_ready), 1);
         @(negedge clk);
         if (i == 1) begin
            req0_a = 32'h7F00_0000; req0_b = 32'h7F00_0000;
         end
         wait_resp(exp_w, t1);
         check($sformatf("t3_res%0d", i), exp_w == 1 ? resp1_result : resp0_result, exp_res[i]);
         check($sformatf("t3_ov%0d", i), 32'(exp_w == 1 ? resp1_overflow : resp0_overflow), 32'(exp_ov[i]));
         consume(exp_w);
      end
      req0_valid = 0; req1_valid = 0;

      // back-pressure on resp1
      req1_valid = 1;
      wait_ready(1, t0);
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
      wait_resp(1, t1);
      for (int i = 0; i < 5; i++) begin
         check("t4_v1", 32'(resp1_valid), 1);
         check("t4_res1", resp1_result, 32'h4000_0000);
         check("t4_rdy0", 32'(req0_ready), 0);
         check("t4_rdy1", 32'(req1_ready), 0);
         @(negedge clk); #1;
      end
      consume(1);
      check("t4_next_rdy0", 32'(req0_ready), 1);
      check("t4_next_rdy1", 32'(req1_ready), 0);
      @(negedge clk); req0_valid = 0; req1_valid = 0;
      wait_resp(0, t1);
      check("t4_res0", resp0_result, 32'h40C0_0000);
      consume(0);

`ifdef FPU_ARB_TIMEOUT_EN
      // timeout abort, late done ignored
      mute = 1;
      req0_valid = 1; req0_op = 1; req0_a = 32'h4120_0000; req0_b = 32'h40A0_0000;
      wait_ready(0, t0);
      @(negedge clk); req0_valid = 0;
      wait_resp(0, t1);
      check("t5_lat", 32'(t1 - t0), 18);
      check("t5_res", resp0_result, 32'h7FC0_0000);
      check("t5_err", 32'(resp0_error), 1);
      check("t5_ov", 32'(resp0_overflow), 0);
      force_done = 1; @(negedge clk); force_done = 0; #1;
      check("t5_late_v", 32'(resp0_valid), 1);
      check("t5_late_res", resp0_result, 32'h7FC0_0000);
      check("t5_late_err", 32'(resp0_error), 1);
      consume(0);
      force_done = 1; @(negedge clk); force_done = 0; #1;
      check("t5_idle_busy", 32'(busy), 0);
      check("t5_idle_v0", 32'(resp0_valid), 0);
      check("t5_idle_start", 32'(fpu_start), 0);
      // done on the timeout cycle wins
      req0_valid = 1;
      wait_ready(0, t0);
      @(negedge clk); req0_valid = 0;
      repeat (16) @(negedge clk);
      force_done = 1; @(negedge clk); force_done = 0; #1;
      check("t5_race_v", 32'(resp0_valid), 1);
      check("t5_race_res", resp0_result, 32'h4170_0000);
      check("t5_race_err", 32'(resp0_error), 0);
      consume(0);
      mute = 0;
`endif

      // reset during WAIT
      req0_valid = 1; req0_op = 0; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
      wait_ready(0, t0);
      @(negedge clk); req0_valid = 0;
      repeat (3) @(negedge clk);
      check("t6_busy_pre", 32'(busy), 1);
      reset = 1; #1;
      check("t6_busy", 32'(busy), 0);
      check("t6_start", 32'(fpu_start), 0);
      check("t6_op", 32'(fpu_op), 0);
      check("t6_a", fpu_a, 0);
      check("t6_v0", 32'(resp0_valid), 0);
      check("t6_res0", resp0_result, 0);
      @(negedge clk); reset = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         check("t6_no_start", 32'(fpu_start | resp0_valid), 0);
      end
      req0_valid = 1; req0_op = 1; req0_a = 32'h4120_0000; req0_b = 32'h40A0_0000;
      req1_valid = 1; req1_op = 1; req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
      #1;
      check("t6_rdy0", 32'(req0_ready), 1);
      check("t6_rdy1", 32'(req1_ready), 0);
      t0 = cyc;
      @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
      check("t6_start_new", 32'(fpu_start), 1);
      wait_resp(0, t1);
      check("t6_lat", 32'(t1 - t0), 10);
      check("t6_res", resp0_result, 32'h4170_0000);
      consume(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and issue sequencer that shares one floating-point add/multiply unit (datapath plus its control FSM) between two requesters. Each requester hands over an operation (soma or multiplica) and two IEEE-754 single-precision operands via a valid/ready handshake. The block issues the operation with a one-cycle start pulse, waits for completion, and returns the result on the winning requester's response channel. It sits directly above the FP control unit, which keeps normalization and rounding to itself.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the operation is aborted (must be >= 2; only used with FPU_ARB_TIMEOUT_EN).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  requester N is accepted this cycle
- req0_op / req1_op  in  1  1 = soma, 0 = multiplica
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- resp0_valid / resp1_valid  out  1  response for requester N held
- resp0_ready / resp1_ready  in  1  requester N consumes response
- resp0_result / resp1_result  out  32  result word
- resp0_overflow / resp1_overflow  out  1  overflow flag from FP unit
- resp0_error / resp1_error  out  1  operation aborted by timeout
- fpu_start  out  1  one-cycle start pulse to FP control unit
- fpu_op  out  1  registered operation select
- fpu_a, fpu_b  out  32  registered operands, stable from ISSUE until next accept
- fpu_done  in  1  FP unit completion strobe
- fpu_result  in  32  FP unit result, valid with fpu_done
- fpu_overflow  in  1  FP unit overflow, valid with fpu_done
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: the grant is combinational. With only one reqN_valid high, N wins. With both high, the requester not in `last` wins. reqN_ready = (state==IDLE) && grant==N. On the handshake: latch op/a/b into fpu_*, record owner=N, set last=N, go to ISSUE.
- ISSUE: fpu_start=1 for exactly this cycle. Clear timeout counter. fpu_done is ignored in this state. Go to WAIT.
- WAIT: on fpu_done, capture fpu_result and fpu_overflow, set error=0, go to RESP.
- RESP: respOWNER_valid=1 with the captured result/overflow/error held stable. The other resp_valid stays 0. On respOWNER_ready go to IDLE; resp_valid drops in the IDLE cycle.
- Requests are never accepted outside IDLE; requesters hold valid and payload until ready.
- fpu_done outside WAIT is discarded.
- Reset values: state=IDLE, last=1 (req0 wins the first tie), owner=0, fpu_start=0, fpu_op=0, fpu_a/fpu_b=0, all resp*_valid/result/overflow/error=0, busy=0, counter=0.
- Reset mid-operation: return to IDLE immediately. Any pending response is lost. No fpu_start is emitted until a new accept.

## Timing
- Accept at cycle T, fpu_start at T+1, WAIT from T+2.
- fpu_done sampled at cycle D gives resp_valid from D+1.
- Response consumed at cycle R gives IDLE at R+1. The next accept is possible at R+1, so the minimum turnaround is 3 cycles plus the FP latency.
- Timeout: the counter increments each WAIT cycle without fpu_done. If the counter equals TIMEOUT_CYCLES-1 and fpu_done is low, go to RESP with result=32'h7FC00000, overflow=0, error=1.
- fpu_done arriving in the same cycle as the timeout wins: normal response, error=0.
- Counter width is $clog2(TIMEOUT_CYCLES)+1; it never wraps.

## Configuration
- FPU_ARB_TIMEOUT_EN defined: timeout counter and error path are present as above.
- Not defined: no counter logic. WAIT exits only on fpu_done, and resp0_error/resp1_error are tied to 0.

## Test plan
- The bench uses a behavioural FP model with a fixed latency of 8 cycles after fpu_start.
- Single soma from req0, a=0x41200000, b=0x40A00000: fpu_start 1 cycle after accept; resp0_result=0x41700000, overflow=0, error=0 at accept+10; resp1_valid stays 0.
- Simultaneous requests from reset, req0 multiplica 0x40000000*0x40400000 and req1 soma 0x3F800000+0x3F800000: req0 served first with 0x40C00000; req1 accepted the cycle after resp0 handshake, result 0x40000000.
- Back-to-back contention with both valid for 4 operations: grants alternate 0,1,0,1; none starves.
- Back-pressure: resp1_ready held low 5 cycles; resp1_valid and resp1_result stay stable, no new accept; both requests wait with ready=0.
- With FPU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the model never asserts fpu_done: resp0_valid at accept+18 with result=0x7FC00000, error=1. A late fpu_done in RESP or IDLE is ignored.
- Reset asserted during WAIT: busy=0 and all outputs at reset values immediately; the next request issues normally with req0 priority on a tie.
